part_2_targ_bridge: RTL and testbench
=====================================

Name: part_2_targ_bridge

Overview:
- Target-side end of the partition-2 co-simulation link; counterpart of the initiator interface.
- Accepts 9-bit joined vectors {wen,data} for slots 0..2 from the link and unpacks them to the target partition's wen0..2/i_data0..2.
- Once per mission clock edge, applies those vectors, captures the target's {valid,o_data} and returns it on slot 3.
- Freezes the mission clock generator while inbound data or the outbound handshake is outstanding.

Parameters:
- W, 9, joined vector width (1 strobe bit + 8 data bits).
- SETTLE, 1, clk_i cycles the unpacked inputs are held before the target response is captured; legal range 1..15.
- WATCHDOG_MAX, 10000, clk_i cycles allowed in WAIT_RX or SEND before a fatal error.
- WD_W, 14, watchdog counter width; must satisfy 2**WD_W > WATCHDOG_MAX.

Ports:
- clk_i  in  1  utility clock.
- rst_ni  in  1  asynchronous, active-low reset.
- clk_mission_i  in  1  target mission clock, sampled on clk_i.
- rx_valid_i  in  1  inbound vector valid.
- rx_ready_o  out  1  inbound vector accepted.
- rx_slot_i  in  2  inbound slot index.
- rx_data_i  in  W  inbound joined vector.
- tx_valid_o  out  1  outbound vector valid.
- tx_ready_i  in  1  outbound vector accepted.
- tx_slot_o  out  2  outbound slot index; constant 3.
- tx_data_o  out  W  outbound {valid,o_data}.
- wen0_o/wen1_o/wen2_o  out  1 each  unpacked write strobes.
- i_data0_o/i_data1_o/i_data2_o  out  8 each  unpacked data.
- valid_i  in  1  target response valid.
- o_data_i  in  8  target response data.
- freeze_clk_o  out  1  holds the mission clock generator.
- wd_err_o  out  1  sticky watchdog error.
- ovr_err_o  out  1  sticky mission-edge overrun.

Behaviour:
- Reset: all outputs 0, state IDLE, slot flags 0, watchdog 0, edge_pending 0. Reset asserted mid-operation aborts immediately; partially received slots are discarded.
- Edge detection: two flops d1,d2 on clk_mission_i. Strobe = d1 & !d2, one clk_i cycle per rising edge.
- Strobe handling:
  - Strobe in IDLE starts a transaction.
  - Strobe in any other state sets edge_pending.
  - Strobe while edge_pending is already 1 sets ovr_err_o; the extra edge is dropped.
  - A pending edge starts the next transaction on the first IDLE cycle.
- Inbound handshake:
  - Transfer when rx_valid_i & rx_ready_o.
  - rx_ready_o = (rx_slot_i==3) | !flag[rx_slot_i], in every state except ERR; 0 in ERR.
  - Slot 0..2 transfer: stores rx_data_i in hold[slot] and sets flag[slot]. Allowed in any state, including ahead of the edge.
  - Slot 3 transfer: accepted and dropped.
- FSM:
  - IDLE: freeze 0. On strobe or pending → WAIT_RX; clear edge_pending and watchdog.
  - WAIT_RX: freeze 1. When flags==3'b111 → APPLY: load all unpacked outputs from hold, clear all flags. A transfer arriving in the same cycle sets its flag after the clear. Otherwise watchdog+1.
  - APPLY: freeze 0. Hold for SETTLE cycles (internal counter), then → CAPTURE.
  - CAPTURE: register tx_data_o <= {valid_i,o_data_i}, set tx_valid_o=1 → SEND.
  - SEND: freeze 1. When tx_valid_o & tx_ready_i, clear tx_valid_o → IDLE. Otherwise watchdog+1. tx_data_o stays stable while tx_valid_o is high.
  - ERR: entered from WAIT_RX or SEND when watchdog reaches WATCHDOG_MAX. wd_err_o=1, freeze 1, tx_valid_o=0. Exit only by reset.
- Unpacked outputs hold their values between APPLY loads. Unpacking: wenN_o = hold[N][8], i_dataN_o = hold[N][7:0].
- Latency (E = strobe cycle, slots prefilled): WAIT_RX at E+1, outputs valid at E+2, tx_valid_o first high at E+3+SETTLE.

Decomposition:
- Package part_2_bridge_pkg:
  - state enum (IDLE, WAIT_RX, APPLY, CAPTURE, SEND, ERR);
  - slot constants SLOT_IN0..2 = 0..2, SLOT_RESP = 3;
  - joined vector typedef of width 9.
- Sub-module part_2_edge_det: 2-flop sampler plus rising-edge strobe, async active-low reset.

Test Plan:
- Prefill slots 0/1/2 with 9'h1A5/9'h03C/9'h1FF; one mission edge; target returns 9'h1_7E → wen0_o=1, i_data0_o=A5, wen1_o=0, i_data1_o=3C, wen2_o=1, i_data2_o=FF at E+2; tx_valid_o=1 with tx_data_o=9'h17E, tx_slot_o=3 at E+4; freeze_clk_o=0 throughout.
- Edge first, slot 2 delayed 20 cycles → freeze_clk_o=1 for those cycles; APPLY starts the cycle after slot 2 arrives; data correct.
- Second write to slot 1 before consumption → rx_ready_o=0 for slot 1 until APPLY; the first value is applied.
- tx_ready_i held low 5 cycles → tx_valid_o and tx_data_o stable, freeze_clk_o=1; transfer completes on cycle 6.
- No inbound data for WATCHDOG_MAX cycles → wd_err_o=1 and state ERR; rx_ready_o=0; cleared only by rst_ni low mid-test, after which all outputs are 0.
- Three mission edges during one WAIT_RX → edge_pending serves the next transaction; ovr_err_o=1.

Source files
------------

// File: rtl/part_2_bridge_pkg.sv
// Shared types and constants for the partition-2 target-side link bridge.
//   state_t  : bridge FSM states
//   vec_t    : joined link vector {strobe/valid, data[7:0]}
//   SLOT_*   : link slot indices (three inbound vectors, one response)
package part_2_bridge_pkg;

    localparam int VEC_W = 9;

    typedef logic [VEC_W-1:0] vec_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RX,
        APPLY,
        CAPTURE,
        SEND,
        ERR
    } state_t;

    localparam logic [1:0] SLOT_IN0  = 2'd0;
    localparam logic [1:0] SLOT_IN1  = 2'd1;
    localparam logic [1:0] SLOT_IN2  = 2'd2;
    localparam logic [1:0] SLOT_RESP = 2'd3;

endpackage

// File: rtl/part_2_edge_det.sv
// Rising-edge detector for a slow clock sampled in the utility clock domain.
//   clk, rst_n : utility clock, asynchronous active-low reset
//   level      : slow signal to watch (mission clock)
//   rise       : one-cycle strobe for every sampled 0->1 transition
module part_2_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic d1;
    logic d2;

    // NOTE: sequential state uses non-blocking assignments so d2 sees the
    // old d1 and the two flops behave as a shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= level;
            d2 <= d1;
        end
    end

    assign rise = d1 & ~d2;

endmodule

// File: rtl/part_2_targ_bridge.sv
// Target-side end of the partition-2 co-simulation link.
// Collects joined vectors for slots 0..2, applies them to the target once per
// mission clock edge, captures the target's {valid,o_data} and returns it on
// slot 3. The mission clock generator is frozen while inbound vectors or the
// outbound handshake are outstanding.
//   clk_i, rst_ni                 : utility clock, async active-low reset
//   clk_mission_i                 : mission clock, sampled on clk_i
//   rx_valid_i/rx_ready_o/rx_slot_i/rx_data_i : inbound link channel
//   tx_valid_o/tx_ready_i/tx_slot_o/tx_data_o : outbound link channel
//   wen0..2_o, i_data0..2_o       : unpacked target inputs
//   valid_i, o_data_i             : target response
//   freeze_clk_o                  : holds the mission clock generator
//   wd_err_o, ovr_err_o           : sticky watchdog / edge-overrun errors
module part_2_targ_bridge
    import part_2_bridge_pkg::*;
#(
    parameter int W            = 9,
    parameter int SETTLE       = 1,
    parameter int WATCHDOG_MAX = 10000,
    parameter int WD_W         = 14
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clk_mission_i,
    input  logic         rx_valid_i,
    output logic         rx_ready_o,
    input  logic [1:0]   rx_slot_i,
    input  logic [W-1:0] rx_data_i,
    output logic         tx_valid_o,
    input  logic         tx_ready_i,
    output logic [1:0]   tx_slot_o,
    output logic [W-1:0] tx_data_o,
    output logic         wen0_o,
    output logic         wen1_o,
    output logic         wen2_o,
    output logic [7:0]   i_data0_o,
    output logic [7:0]   i_data1_o,
    output logic [7:0]   i_data2_o,
    input  logic         valid_i,
    input  logic [7:0]   o_data_i,
    output logic         freeze_clk_o,
    output logic         wd_err_o,
    output logic         ovr_err_o
);

    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(WATCHDOG_MAX - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    state_t          state;
    logic [2:0]      flags;
    vec_t            hold [3];
    logic [WD_W-1:0] wd;
    logic [3:0]      settle_cnt;
    logic            edge_pending;
    logic            out_en;
    logic            strobe;
    logic            rx_fire;
    logic            apply;
    logic [3:0]      busy;
    logic [3:0]      slot_hot;
    logic [2:0]      flag_set;

    part_2_edge_det u_edge_det (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .level (clk_mission_i),
        .rise  (strobe)
    );

    // Slot 3 is never busy: response-slot vectors are accepted and dropped.
    // out_en keeps the combinational handshake/slot outputs at 0 during reset.
    assign busy       = {1'b0, flags};
    assign rx_ready_o = out_en && (state != ERR) && !busy[rx_slot_i];
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign slot_hot   = 4'b0001 << rx_slot_i;
    assign flag_set   = rx_fire ? slot_hot[2:0] : 3'b000;
    assign apply      = (state == WAIT_RX) && (flags == 3'b111);
    assign tx_slot_o  = out_en ? SLOT_RESP : 2'b00;

    // Freeze is driven from the live handshake condition so the mission clock
    // is released in the same cycle the last slot or the tx_ready arrives.
    assign freeze_clk_o = ((state == WAIT_RX) && !apply)
                       || ((state == SEND) && !tx_ready_i)
                       || (state == ERR);

    // NOTE: hold is plain data qualified by flags, so it carries no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 3; i++) begin
            if (flag_set[i]) hold[i] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            flags        <= 3'b000;
            wd           <= '0;
            settle_cnt   <= '0;
            edge_pending <= 1'b0;
            out_en       <= 1'b0;
            tx_valid_o   <= 1'b0;
            tx_data_o    <= '0;
            wen0_o       <= 1'b0;
            wen1_o       <= 1'b0;
            wen2_o       <= 1'b0;
            i_data0_o    <= '0;
            i_data1_o    <= '0;
            i_data2_o    <= '0;
            wd_err_o     <= 1'b0;
            ovr_err_o    <= 1'b0;
        end else begin
            out_en <= 1'b1;
            // A vector landing in the apply cycle survives the clear.
            flags  <= (apply ? 3'b000 : flags) | flag_set;

            // Outside IDLE one edge may be queued; a second one is dropped.
            if (strobe && (state != IDLE)) begin
                if (edge_pending) ovr_err_o <= 1'b1;
                edge_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (strobe || edge_pending) begin
                        state        <= WAIT_RX;
                        wd           <= '0;
                        // Queued edge starts now; a coincident fresh edge stays queued.
                        edge_pending <= strobe && edge_pending;
                    end
                end
                WAIT_RX: begin
                    if (apply) begin
                        state      <= APPLY;
                        settle_cnt <= '0;
                        wen0_o     <= hold[SLOT_IN0][VEC_W-1];
                        i_data0_o  <= hold[SLOT_IN0][7:0];
                        wen1_o     <= hold[SLOT_IN1][VEC_W-1];
                        i_data1_o  <= hold[SLOT_IN1][7:0];
                        wen2_o     <= hold[SLOT_IN2][VEC_W-1];
                        i_data2_o  <= hold[SLOT_IN2][7:0];
                    end else if (wd == WD_LAST) begin
                        state    <= ERR;
                        wd_err_o <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
                    else                           settle_cnt <= settle_cnt + 1'b1;
                end
                CAPTURE: begin
                    tx_data_o  <= {valid_i, o_data_i};
                    tx_valid_o <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        state      <= IDLE;
                    end else if (wd == WD_LAST) begin
                        tx_valid_o <= 1'b0;
                        state      <= ERR;
                        wd_err_o   <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ERR: begin
                    tx_valid_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_part_2_targ_bridge.sv
// Self-checking bench for part_2_targ_bridge: directed link scenarios plus
// randomized transactions compared against a slot-level reference model.
module tb_part_2_targ_bridge;

    localparam int W            = 9;
    localparam int SETTLE       = 1;
    localparam int WATCHDOG_MAX = 10000;
    localparam int WD_W         = 14;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         clk_mission_i = 1'b0;
    logic         rx_valid_i = 1'b0;
    logic [1:0]   rx_slot_i = 2'd0;
    logic [W-1:0] rx_data_i = '0;
    logic         tx_ready_i = 1'b0;
    logic         valid_i = 1'b0;
    logic [7:0]   o_data_i = 8'h00;
    logic         rx_ready_o;
    logic         tx_valid_o;
    logic [1:0]   tx_slot_o;
    logic [W-1:0] tx_data_o;
    logic         wen0_o, wen1_o, wen2_o;
    logic [7:0]   i_data0_o, i_data1_o, i_data2_o;
    logic         freeze_clk_o, wd_err_o, ovr_err_o;

    int vectors = 0;
    int miscompares = 0;

    part_2_targ_bridge #(
        .W(W), .SETTLE(SETTLE), .WATCHDOG_MAX(WATCHDOG_MAX), .WD_W(WD_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clk_mission_i (clk_mission_i),
        .rx_valid_i    (rx_valid_i),
        .rx_ready_o    (rx_ready_o),
        .rx_slot_i     (rx_slot_i),
        .rx_data_i     (rx_data_i),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i),
        .tx_slot_o     (tx_slot_o),
        .tx_data_o     (tx_data_o),
        .wen0_o        (wen0_o),
        .wen1_o        (wen1_o),
        .wen2_o        (wen2_o),
        .i_data0_o     (i_data0_o),
        .i_data1_o     (i_data1_o),
        .i_data2_o     (i_data2_o),
        .valid_i       (valid_i),
        .o_data_i      (o_data_i),
        .freeze_clk_o  (freeze_clk_o),
        .wd_err_o      (wd_err_o),
        .ovr_err_o     (ovr_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Mission clock high for one utility cycle; returns in the strobe cycle E.
    task automatic mission_pulse();
        clk_mission_i = 1'b1;
        tick();
        clk_mission_i = 1'b0;
    endtask

    // Offer one inbound vector and wait (bounded) until it is taken.
    task automatic rx_push(input logic [1:0] slot, input logic [8:0] data);
        int n = 0;
        rx_valid_i = 1'b1;
        rx_slot_i  = slot;
        rx_data_i  = data;
        #1;
        while (!rx_ready_o && n < 200) begin
            tick();
            n++;
        end
        check("rx_accept", rx_ready_o, 1);
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_tx(input int bound);
        int n = 0;
        while (!tx_valid_o && n < bound) begin
            tick();
            n++;
        end
        check("tx_valid_seen", tx_valid_o, 1);
    endtask

    task automatic check_unpacked(input string tag, input logic [8:0] e0,
                                  input logic [8:0] e1, input logic [8:0] e2);
        check({tag, "_slot0"}, {wen0_o, i_data0_o}, e0);
        check({tag, "_slot1"}, {wen1_o, i_data1_o}, e1);
        check({tag, "_slot2"}, {wen2_o, i_data2_o}, e2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"}, rx_ready_o, 0);
        check({tag, "_tx_valid"}, tx_valid_o, 0);
        check({tag, "_tx_slot"}, tx_slot_o, 0);
        check({tag, "_tx_data"}, tx_data_o, 0);
        check_unpacked(tag, 9'h000, 9'h000, 9'h000);
        check({tag, "_freeze"}, freeze_clk_o, 0);
        check({tag, "_wd_err"}, wd_err_o, 0);
        check({tag, "_ovr_err"}, ovr_err_o, 0);
    endtask

    initial begin
        // Reset: every output low, even with a response-slot vector offered.
        rx_valid_i = 1'b1;
        rx_slot_i  = 2'd3;
        tick();
        tick();
        check_all_zero("reset");
        rx_valid_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        tick();

        // Prefilled slots, one mission edge, response returned at E+4.
        tx_ready_i = 1'b1;
        valid_i    = 1'b1;
        o_data_i   = 8'h7E;
        rx_push(2'd0, 9'h1A5);
        rx_push(2'd1, 9'h03C);
        rx_push(2'd2, 9'h1FF);
        check("t1_freeze_pre", freeze_clk_o, 0);
        mission_pulse();                            // E
        check("t1_freeze_e0", freeze_clk_o, 0);
        tick();                                     // E+1
        check("t1_freeze_e1", freeze_clk_o, 0);
        tick();                                     // E+2
        check_unpacked("t1_e2", 9'h1A5, 9'h03C, 9'h1FF);
        check("t1_freeze_e2", freeze_clk_o, 0);
        tick();                                     // E+3
        check("t1_txv_e3", tx_valid_o, 0);
        check("t1_freeze_e3", freeze_clk_o, 0);
        tick();                                     // E+4
        check("t1_txv_e4", tx_valid_o, 1);
        check("t1_txdata_e4", tx_data_o, 9'h17E);
        check("t1_txslot_e4", tx_slot_o, 3);
        check("t1_freeze_e4", freeze_clk_o, 0);
        tick();                                     // E+5
        check("t1_txv_e5", tx_valid_o, 0);

        // Edge first, slot 2 delayed 20 cycles.
        valid_i  = 1'b0;
        o_data_i = 8'h5A;
        rx_push(2'd0, 9'h111);
        rx_push(2'd1, 9'h022);
        mission_pulse();
        tick();                                     // E+1, waiting on slot 2
        for (int i = 0; i < 20; i++) begin
            check("t2_freeze_wait", freeze_clk_o, 1);
            tick();
        end
        rx_push(2'd2, 9'h1C3);                      // now in the arrival cycle
        check("t2_freeze_arrive", freeze_clk_o, 0);
        check("t2_old_slot2_held", {wen2_o, i_data2_o}, 9'h1FF);
        tick();                                     // APPLY
        check_unpacked("t2_apply", 9'h111, 9'h022, 9'h1C3);
        wait_tx(20);
        check("t2_txdata", tx_data_o, 9'h05A);
        tick();

        // Second write to slot 1 before consumption is held off until APPLY.
        valid_i  = 1'b1;
        o_data_i = 8'h99;
        rx_push(2'd0, 9'h0AA);
        rx_push(2'd1, 9'h155);
        rx_push(2'd2, 9'h033);
        rx_valid_i = 1'b1;
        rx_slot_i  = 2'd1;
        rx_data_i  = 9'h0EE;
        #1;
        check("t3_ready_blocked_pre", rx_ready_o, 0);
        mission_pulse();                            // E
        check("t3_ready_blocked_e0", rx_ready_o, 0);
        tick();                                     // E+1
        check("t3_ready_blocked_e1", rx_ready_o, 0);
        tick();                                     // E+2, APPLY
        check("t3_ready_apply", rx_ready_o, 1);
        check_unpacked("t3_apply", 9'h0AA, 9'h155, 9'h033);
        tick();                                     // second slot-1 vector taken
        rx_valid_i = 1'b0;
        wait_tx(20);
        check("t3_txdata", tx_data_o, 9'h199);
        tick();

        // tx_ready held low for 5 cycles; slot 1 already holds 0x0EE.
        tx_ready_i = 1'b0;
        valid_i    = 1'b0;
        o_data_i   = 8'h3C;
        rx_push(2'd0, 9'h101);
        rx_push(2'd2, 9'h0F0);
        mission_pulse();
        tick();
        tick();
        tick();
        tick();                                     // E+4, SEND
        check_unpacked("t4_apply", 9'h101, 9'h0EE, 9'h0F0);
        valid_i  = 1'b1;
        o_data_i = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("t4_txv_stall", tx_valid_o, 1);
            check("t4_txdata_stall", tx_data_o, 9'h03C);
            check("t4_freeze_stall", freeze_clk_o, 1);
            tick();
        end
        tx_ready_i = 1'b1;                          // sixth cycle
        #1;
        check("t4_freeze_release", freeze_clk_o, 0);
        check("t4_txv_sixth", tx_valid_o, 1);
        tick();
        check("t4_txv_done", tx_valid_o, 0);

        // Randomized transactions against the slot-level model: each slot
        // presents the vector written since the last apply, and slot 3
        // returns whatever the target drives.
        for (int t = 0; t < 16; t++) begin
            logic [8:0] h [3];
            logic [8:0] resp;
            int         k;
            int         dly;
            for (int s = 0; s < 3; s++) h[s] = 9'($urandom);
            resp     = 9'($urandom);
            k        = int'($urandom_range(0, 3));
            dly      = int'($urandom_range(0, 4));
            valid_i  = resp[8];
            o_data_i = resp[7:0];
            tx_ready_i = (dly == 0);
            for (int s = 0; s < k; s++) rx_push(2'(s), h[s]);
            mission_pulse();
            for (int s = k; s < 3; s++) begin
                repeat (int'($urandom_range(0, 3))) tick();
                rx_push(2'(s), h[s]);
            end
            wait_tx(50);
            check_unpacked("rnd", h[0], h[1], h[2]);
            check("rnd_txdata", tx_data_o, resp);
            repeat (dly) tick();
            tx_ready_i = 1'b1;
            tick();
            check("rnd_txv_done", tx_valid_o, 0);
        end

        // Three mission edges during one WAIT_RX.
        valid_i  = 1'b1;
        o_data_i = 8'h42;
        mission_pulse();                            // starts WAIT_RX
        tick();
        tick();
        mission_pulse();                            // queued
        tick();
        check("t6_ovr_after_2", ovr_err_o, 0);
        mission_pulse();                            // dropped
        tick();
        check("t6_ovr_after_3", ovr_err_o, 1);
        rx_push(2'd0, 9'h00F);
        rx_push(2'd1, 9'h1F0);
        rx_push(2'd2, 9'h055);
        wait_tx(20);
        check("t6_txdata_first", tx_data_o, 9'h142);
        tick();                                     // IDLE
        tick();                                     // queued edge -> WAIT_RX
        check("t6_pending_freeze", freeze_clk_o, 1);
        o_data_i = 8'h24;
        rx_push(2'd0, 9'h1E1);
        rx_push(2'd1, 9'h0D2);
        rx_push(2'd2, 9'h1C3);
        wait_tx(20);
        check_unpacked("t6_second", 9'h1E1, 9'h0D2, 9'h1C3);
        check("t6_txdata_second", tx_data_o, 9'h124);
        check("t6_ovr_sticky", ovr_err_o, 1);
        tick();

        // Watchdog: no inbound data for WATCHDOG_MAX cycles in WAIT_RX.
        mission_pulse();                            // E; WAIT_RX from E+1
        repeat (WATCHDOG_MAX) tick();               // E+WATCHDOG_MAX
        check("t7_wd_not_yet", wd_err_o, 0);
        tick();
        check("t7_wd_err", wd_err_o, 1);
        check("t7_freeze_err", freeze_clk_o, 1);
        check("t7_txv_err", tx_valid_o, 0);
        rx_valid_i = 1'b1;
        rx_slot_i  = 2'd0;
        #1;
        check("t7_ready_err_slot0", rx_ready_o, 0);
        rx_slot_i = 2'd3;
        #1;
        check("t7_ready_err_slot3", rx_ready_o, 0);
        tick();
        check("t7_wd_sticky", wd_err_o, 1);
        rst_ni = 1'b0;
        #1;
        check_all_zero("t7_reset");
        rx_valid_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        check("t7_wd_cleared", wd_err_o, 0);

        // Recovery after reset.
        valid_i  = 1'b0;
        o_data_i = 8'h81;
        rx_push(2'd0, 9'h1AB);
        rx_push(2'd1, 9'h0CD);
        rx_push(2'd2, 9'h1EF);
        mission_pulse();
        wait_tx(20);
        check_unpacked("t8", 9'h1AB, 9'h0CD, 9'h1EF);
        check("t8_txdata", tx_data_o, 9'h081);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
